wieg_strategie: RTL
===================

Name: wieg_strategie

Overview:
- Rocking-strategy controller directly downstream of the stress-trend detector.
- Consumes the 3-bit cry-stress level plus the detector's `gedaald` (stress dropped) and `gelijk` (stress unchanged two samples) flags.
- Decides the rocking intensity step `stand` driven to the motor controller, and raises `alarm` when maximum rocking does not help.
- Decisions are paced by an evaluation strobe, not every clock.

Parameters:
- MAX_STAND, 7: highest rocking intensity step; must fit in 3 bits.
- WAIT_TICKS, 4: consecutive `gelijk` ticks before escalating `stand`.
- CALM_TICKS, 8: consecutive ticks with status==0 before rocking stops.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- tick  input  1  one-cycle evaluation strobe; inputs below are only acted on when tick=1.
- status  input  3  current stress level, 0 = calm, 7 = max.
- gedaald  input  1  from trend detector: status lower than previous sample.
- gelijk  input  1  from trend detector: status equal for two consecutive samples.
- stand  output  3  rocking intensity step, 0 = motor off.
- actief  output  1  high whenever state != RUST.
- wissel  output  1  one-cycle pulse in the cycle after `stand` changes.
- alarm  output  1  high while in ALARM.

Behaviour:
- All outputs are registered and update on the clock edge where tick=1; with tick=0, state, counters and outputs hold, and wissel=0.
- Reset (sync, active-high, overrides tick):
  - state=RUST, stand=0, actief=0, wissel=0, alarm=0.
  - wait_cnt=0, calm_cnt=0.
  - Reset mid-operation aborts immediately with these values.
- Counters: width clog2(max(WAIT_TICKS,CALM_TICKS))+1; saturate, never wrap.
- States: RUST, WIEGEN, KALMEREN, ALARM.
- RUST, on tick:
  - status!=0 -> WIEGEN, stand=1, wissel=1, wait_cnt=0.
  - Otherwise stay.
- WIEGEN, on tick, priority order:
  - (1) status==0 -> KALMEREN, calm_cnt=1, stand held.
  - (2) gedaald=1 -> stay, wait_cnt=0, stand held (strategy works).
  - (3) gelijk=1 -> wait_cnt+1. When the new value reaches WAIT_TICKS:
    - If stand<MAX_STAND: stand+1, wissel=1, wait_cnt=0.
    - If stand==MAX_STAND and status>=6: -> ALARM, alarm=1, wait_cnt=0.
    - If stand==MAX_STAND and status<6: wait_cnt saturates, no change.
  - (4) else (stress rising or first equal sample) -> wait_cnt=0, no change.
- KALMEREN, on tick:
  - status==0: calm_cnt+1. When it reaches CALM_TICKS -> RUST, stand=0, wissel=1, calm_cnt=0.
  - status!=0 -> WIEGEN, calm_cnt=0, wait_cnt=0, stand held.
- ALARM (stand held at MAX_STAND), on tick:
  - status==0 -> KALMEREN, alarm=0, calm_cnt=1.
  - else gedaald=1 -> WIEGEN, alarm=0, wait_cnt=0.
  - Otherwise stay.
- actief is registered: 1 in WIEGEN, KALMEREN, ALARM; 0 in RUST.
- wissel never fires without a real change of stand.
- Simultaneous gedaald=1 and gelijk=1 cannot occur upstream; if it does, gedaald wins by the priority order.

Decomposition:
- Shared package:
  - State enum: RUST, WIEGEN, KALMEREN, ALARM.
  - STAND_W=3, STATUS_W=3.
  - ALARM_LEVEL=6 threshold constant.
- One natural sub-module: `tick_teller`, a saturating counter with clear/increment/enable, instantiated twice (wait_cnt, calm_cnt).

Test Plan:
- Reset mid-WIEGEN with stand=3 -> next cycle stand=0, actief=0, alarm=0, wissel=0, state RUST.
- From RUST, tick with status=4 -> stand=1, wissel pulse 1 cycle, actief=1.
- WIEGEN with status=5, gelijk=1 for 4 ticks (tick every 10 clks) -> stand 1->2 after 4th tick; 12 more gelijk ticks -> stand=5; tick=0 cycles cause no change.
- stand=7, status=7, gelijk for 4 ticks -> alarm=1. Then a tick with gedaald=1 -> alarm=0, state WIEGEN, stand=7.
- WIEGEN stand=3, status=0 for 7 ticks -> stand=3, actief=1. Status=2 on 8th tick -> back to WIEGEN, calm_cnt=0. Status=0 for 8 ticks -> stand=0, actief=0, one wissel pulse.
- gelijk ticks interleaved with a gedaald tick (3 gelijk, 1 gedaald, 3 gelijk) -> no escalation, stand unchanged.

Source files
------------

// File: rtl/wieg_strategie_pkg.sv
// Shared types and constants for the rocking-strategy controller.
// State encoding, field widths and the alarm stress threshold live here.
package wieg_strategie_pkg;

    localparam int STAND_W  = 3;
    localparam int STATUS_W = 3;

    localparam logic [STATUS_W-1:0] ALARM_LEVEL = 3'd6;

    typedef enum logic [1:0] {
        RUST     = 2'd0,
        WIEGEN   = 2'd1,
        KALMEREN = 2'd2,
        ALARM    = 2'd3
    } state_t;

    // Counter width large enough to hold the larger of two tick limits, plus one bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/wieg_strategie_tick_teller.sv
// Saturating tick counter with enable, clear and increment.
// Clear together with increment loads 1, which restarts counting from this tick.
module tick_teller #(
    parameter int CNT_W   = 4,
    parameter int SAT_VAL = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt,
    output logic [CNT_W-1:0] o_cnt_inc
);

    localparam logic [CNT_W-1:0] SAT_L = CNT_W'(SAT_VAL);
    localparam logic [CNT_W-1:0] ONE_L = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;

    // Value the counter would take on an increment; never passes SAT_VAL.
    assign o_cnt_inc = (r_cnt >= SAT_L) ? SAT_L : (r_cnt + ONE_L);
    assign o_cnt     = r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_en) begin
            if (i_clr) begin
                r_cnt <= i_inc ? ONE_L : '0;
            end else if (i_inc) begin
                r_cnt <= o_cnt_inc;
            end
        end
    end

endmodule

// File: rtl/wieg_strategie.sv
// Rocking-strategy controller: escalates rocking intensity while stress stays flat,
// winds down after a calm period, and raises an alarm when maximum rocking does not help.
module wieg_strategie
    import wieg_strategie_pkg::*;
#(
    parameter int MAX_STAND  = 7,
    parameter int WAIT_TICKS = 4,
    parameter int CALM_TICKS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic [STATUS_W-1:0] status,
    input  logic                gedaald,
    input  logic                gelijk,
    output logic [STAND_W-1:0]  stand,
    output logic                actief,
    output logic                wissel,
    output logic                alarm
);

    localparam int CNT_W = cnt_width(WAIT_TICKS, CALM_TICKS);

    localparam logic [CNT_W-1:0]   WAIT_L = CNT_W'(WAIT_TICKS);
    localparam logic [CNT_W-1:0]   CALM_L = CNT_W'(CALM_TICKS);
    localparam logic [STAND_W-1:0] MAX_L  = STAND_W'(MAX_STAND);
    localparam logic [STAND_W-1:0] ONE_S  = STAND_W'(1);

    state_t             r_state;
    logic [STAND_W-1:0] r_stand;
    logic               r_actief;
    logic               r_wissel;
    logic               r_alarm;

    logic               w_calm_in;
    logic               w_wait_clr;
    logic               w_wait_inc;
    logic               w_calm_clr;
    logic               w_calm_inc;
    logic [CNT_W-1:0]   w_wait_cnt;
    logic [CNT_W-1:0]   w_wait_nxt;
    logic [CNT_W-1:0]   w_calm_cnt;
    logic [CNT_W-1:0]   w_calm_nxt;

    assign w_calm_in = (status == '0);

    tick_teller #(
        .CNT_W   (CNT_W),
        .SAT_VAL (WAIT_TICKS)
    ) u_wait_cnt (
        .clk       (clk),
        .reset     (reset),
        .i_en      (tick),
        .i_clr     (w_wait_clr),
        .i_inc     (w_wait_inc),
        .o_cnt     (w_wait_cnt),
        .o_cnt_inc (w_wait_nxt)
    );

    tick_teller #(
        .CNT_W   (CNT_W),
        .SAT_VAL (CALM_TICKS)
    ) u_calm_cnt (
        .clk       (clk),
        .reset     (reset),
        .i_en      (tick),
        .i_clr     (w_calm_clr),
        .i_inc     (w_calm_inc),
        .o_cnt     (w_calm_cnt),
        .o_cnt_inc (w_calm_nxt)
    );

    // Counter commands for the current state; only take effect on a tick.
    always_comb begin
        w_wait_clr = 1'b0;
        w_wait_inc = 1'b0;
        w_calm_clr = 1'b0;
        w_calm_inc = 1'b0;
        case (r_state)
            RUST: begin
                if (!w_calm_in) begin
                    w_wait_clr = 1'b1;
                end
            end
            WIEGEN: begin
                if (w_calm_in) begin
                    w_calm_clr = 1'b1;
                    w_calm_inc = 1'b1;
                end else if (gedaald) begin
                    w_wait_clr = 1'b1;
                end else if (gelijk) begin
                    if (w_wait_nxt >= WAIT_L &&
                        (r_stand < MAX_L || status >= ALARM_LEVEL)) begin
                        w_wait_clr = 1'b1;
                    end else begin
                        w_wait_inc = 1'b1;
                    end
                end else begin
                    w_wait_clr = 1'b1;
                end
            end
            KALMEREN: begin
                if (w_calm_in) begin
                    if (w_calm_nxt >= CALM_L) begin
                        w_calm_clr = 1'b1;
                    end else begin
                        w_calm_inc = 1'b1;
                    end
                end else begin
                    w_calm_clr = 1'b1;
                    w_wait_clr = 1'b1;
                end
            end
            ALARM: begin
                if (w_calm_in) begin
                    w_calm_clr = 1'b1;
                    w_calm_inc = 1'b1;
                end else if (gedaald) begin
                    w_wait_clr = 1'b1;
                end
            end
            default: begin
                w_wait_clr = 1'b1;
                w_calm_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= RUST;
            r_stand  <= '0;
            r_actief <= 1'b0;
            r_wissel <= 1'b0;
            r_alarm  <= 1'b0;
        end else begin
            r_wissel <= 1'b0;
            if (tick) begin
                case (r_state)
                    RUST: begin
                        if (!w_calm_in) begin
                            r_state  <= WIEGEN;
                            r_stand  <= ONE_S;
                            r_wissel <= (r_stand != ONE_S);
                            r_actief <= 1'b1;
                        end
                    end
                    WIEGEN: begin
                        if (w_calm_in) begin
                            r_state <= KALMEREN;
                        end else if (!gedaald && gelijk && w_wait_nxt >= WAIT_L) begin
                            if (r_stand < MAX_L) begin
                                r_stand  <= r_stand + ONE_S;
                                r_wissel <= 1'b1;
                            end else if (status >= ALARM_LEVEL) begin
                                r_state <= ALARM;
                                r_alarm <= 1'b1;
                            end
                        end
                    end
                    KALMEREN: begin
                        if (w_calm_in) begin
                            if (w_calm_nxt >= CALM_L) begin
                                r_state  <= RUST;
                                r_stand  <= '0;
                                r_wissel <= (r_stand != '0);
                                r_actief <= 1'b0;
                            end
                        end else begin
                            r_state <= WIEGEN;
                        end
                    end
                    ALARM: begin
                        if (w_calm_in) begin
                            r_state <= KALMEREN;
                            r_alarm <= 1'b0;
                        end else if (gedaald) begin
                            r_state <= WIEGEN;
                            r_alarm <= 1'b0;
                        end
                    end
                    default: begin
                        r_state  <= RUST;
                        r_stand  <= '0;
                        r_actief <= 1'b0;
                        r_alarm  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign stand  = r_stand;
    assign actief = r_actief;
    assign wissel = r_wissel;
    assign alarm  = r_alarm;

endmodule
